// File: rtl/cve2_pkg.sv
// Shared core types and constants used by the hardware-loop register file and controller.
package cve2_pkg;

    localparam int unsigned HWLP_N_REGS = 2;

    typedef enum logic {
        HWLP_IDLE     = 1'b0,
        HWLP_JUMP_REQ = 1'b1
    } hwlp_ctrl_state_e;

endpackage

// File: rtl/cve2_hwloop_controller.sv
// Hardware-loop controller: matches the completing ID PC against loop end addresses,
// requests a counter decrement and holds a jump-to-start redirect until fetch accepts it.
module cve2_hwloop_controller
    import cve2_pkg::*;
#(
    parameter int unsigned N_REGS     = HWLP_N_REGS,
    parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REGS-1:0][31:0]      hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0]      hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0]      hwlp_counter_i,
    input  logic [31:0]                  pc_id_i,
    input  logic                         id_valid_i,
    input  logic                         kill_i,
    output logic [N_REGS-1:0]            hwlp_dec_cnt_o,
    output logic                         hwlp_jump_req_o,
    output logic [31:0]                  hwlp_jump_addr_o,
    input  logic                         hwlp_jump_ack_i,
    output logic                         hwlp_stall_o,
    output logic [N_REG_BITS-1:0]        hwlp_active_idx_o
);

    hwlp_ctrl_state_e      state_q, state_d;
    logic [31:0]           jump_addr_q, jump_addr_d;
    logic [N_REG_BITS-1:0] active_idx_q, active_idx_d;
    logic [N_REGS-1:0]     match;
    logic [N_REG_BITS-1:0] sel;
    logic                  any_match;

    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            match[k] = (pc_id_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 32'd0);
        end
    end

    // Scan from the top down so the innermost (lowest-index) matching loop wins.
    always_comb begin
        sel = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel = N_REG_BITS'(k);
            end
        end
    end

    assign any_match = |match;

    always_comb begin
        state_d        = state_q;
        jump_addr_d    = jump_addr_q;
        active_idx_d   = active_idx_q;
        hwlp_dec_cnt_o = '0;

        unique case (state_q)
            HWLP_IDLE: begin
                if (id_valid_i && any_match && !kill_i && rst_n) begin
                    hwlp_dec_cnt_o[sel] = 1'b1;
                    active_idx_d        = sel;
                    // A pre-decrement count of 1 is the final pass: fall through, no redirect.
                    if (hwlp_counter_i[sel] > 32'd1) begin
                        jump_addr_d = hwlp_start_addr_i[sel];
                        state_d     = HWLP_JUMP_REQ;
                    end
                end
            end
            HWLP_JUMP_REQ: begin
                if (kill_i || hwlp_jump_ack_i) begin
                    state_d = HWLP_IDLE;
                end
            end
            default: state_d = HWLP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HWLP_IDLE;
            jump_addr_q  <= '0;
            active_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            jump_addr_q  <= jump_addr_d;
            active_idx_q <= active_idx_d;
        end
    end

    assign hwlp_jump_req_o   = (state_q == HWLP_JUMP_REQ);
    assign hwlp_stall_o      = hwlp_jump_req_o;
    assign hwlp_jump_addr_o  = jump_addr_q;
    assign hwlp_active_idx_o = active_idx_q;

endmodule

// File: tb/tb_cve2_hwloop_controller.sv
// Directed self-checking bench for the hardware-loop controller; the bench plays the
// register file, updating its own counters whenever a decrement is expected.
module tb_cve2_hwloop_controller;

    logic              clk;
    logic              rst_n;
    logic [1:0][31:0]  hwlp_start_addr;
    logic [1:0][31:0]  hwlp_end_addr;
    logic [1:0][31:0]  hwlp_counter;
    logic [31:0]       pc_id;
    logic              id_valid;
    logic              kill;
    logic [1:0]        hwlp_dec_cnt;
    logic              hwlp_jump_req;
    logic [31:0]       hwlp_jump_addr;
    logic              hwlp_jump_ack;
    logic              hwlp_stall;
    logic [0:0]        hwlp_active_idx;

    int check_count;
    int error_count;

    cve2_hwloop_controller #(.N_REGS(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hwlp_start_addr_i (hwlp_start_addr),
        .hwlp_end_addr_i   (hwlp_end_addr),
        .hwlp_counter_i    (hwlp_counter),
        .pc_id_i           (pc_id),
        .id_valid_i        (id_valid),
        .kill_i            (kill),
        .hwlp_dec_cnt_o    (hwlp_dec_cnt),
        .hwlp_jump_req_o   (hwlp_jump_req),
        .hwlp_jump_addr_o  (hwlp_jump_addr),
        .hwlp_jump_ack_i   (hwlp_jump_ack),
        .hwlp_stall_o      (hwlp_stall),
        .hwlp_active_idx_o (hwlp_active_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic valid, input logic kl, input logic ack);
        pc_id         = pc;
        id_valid      = valid;
        kill          = kl;
        hwlp_jump_ack = ack;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dec"},   32'(hwlp_dec_cnt),    32'd0);
        checkOutput({tag, "_req"},   32'(hwlp_jump_req),   32'd0);
        checkOutput({tag, "_stall"}, 32'(hwlp_stall),      32'd0);
        checkOutput({tag, "_addr"},  hwlp_jump_addr,       32'd0);
        checkOutput({tag, "_idx"},   32'(hwlp_active_idx), 32'd0);
    endtask

    // One looping iteration with a one-cycle ack: decrement in T, request in T+1, gone after.
    task automatic loopIteration(input string tag, input logic [31:0] pc, input int idx,
                                 input logic [31:0] exp_addr);
        applyStimulus(pc, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, "_dec"}, 32'(hwlp_dec_cnt), (idx == 0) ? 32'd1 : 32'd2);
        checkOutput({tag, "_req_T"}, 32'(hwlp_jump_req), 32'd0);
        tick();
        hwlp_counter[idx] = hwlp_counter[idx] - 32'd1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput({tag, "_req_T1"}, 32'(hwlp_jump_req), 32'd1);
        checkOutput({tag, "_stall_T1"}, 32'(hwlp_stall), 32'd1);
        checkOutput({tag, "_addr"}, hwlp_jump_addr, exp_addr);
        checkOutput({tag, "_idx"}, 32'(hwlp_active_idx), 32'(idx));
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_req_done"}, 32'(hwlp_jump_req), 32'd0);
    endtask

    initial begin
        check_count     = 0;
        error_count     = 0;
        rst_n           = 1'b0;
        hwlp_start_addr = '0;
        hwlp_end_addr   = '{32'hFFFC, 32'hFFFC};
        hwlp_counter    = '0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkAllZero("reset");
        rst_n = 1'b1;

        // Single loop, 3 iterations
        hwlp_start_addr[0] = 32'h100;
        hwlp_end_addr[0]   = 32'h10C;
        hwlp_counter[0]    = 32'd3;
        loopIteration("single_it1", 32'h10C, 0, 32'h100);
        loopIteration("single_it2", 32'h10C, 0, 32'h100);
        applyStimulus(32'h10C, 1'b1, 1'b0, 1'b0);
        checkOutput("single_it3_dec", 32'(hwlp_dec_cnt), 32'd1);
        tick();
        hwlp_counter[0] = 32'd0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("single_it3_noreq", 32'(hwlp_jump_req), 32'd0);
        checkOutput("single_it3_nostall", 32'(hwlp_stall), 32'd0);

        // Nested loops
        hwlp_start_addr = '{32'h104, 32'h110};
        hwlp_end_addr   = '{32'h130, 32'h120};
        hwlp_counter    = '{32'd2, 32'd2};
        loopIteration("nest_inner", 32'h120, 0, 32'h110);
        loopIteration("nest_outer", 32'h130, 1, 32'h104);

        // Shared end address: loop 0 wins
        hwlp_start_addr = '{32'h300, 32'h200};
        hwlp_end_addr   = '{32'h140, 32'h140};
        hwlp_counter    = '{32'd5, 32'd5};
        loopIteration("shared", 32'h140, 0, 32'h200);

        // Ack held low four cycles, then kill
        hwlp_start_addr = '{32'h0, 32'h400};
        hwlp_end_addr   = '{32'hFFFC, 32'h40C};
        hwlp_counter    = '{32'd0, 32'd4};
        applyStimulus(32'h40C, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_dec", 32'(hwlp_dec_cnt), 32'd1);
        tick();
        hwlp_counter[0] = 32'd3;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h40C, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("hold%0d_req", i), 32'(hwlp_jump_req), 32'd1);
            checkOutput($sformatf("hold%0d_stall", i), 32'(hwlp_stall), 32'd1);
            checkOutput($sformatf("hold%0d_addr", i), hwlp_jump_addr, 32'h400);
            checkOutput($sformatf("hold%0d_nodec", i), 32'(hwlp_dec_cnt), 32'd0);
            tick();
        end
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("kill_req_same_cycle", 32'(hwlp_jump_req), 32'd1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("kill_req_dropped", 32'(hwlp_jump_req), 32'd0);
        checkOutput("kill_stall_dropped", 32'(hwlp_stall), 32'd0);
        checkOutput("kill_addr_held", hwlp_jump_addr, 32'h400);

        // Kill in IDLE suppresses decrement and jump
        applyStimulus(32'h40C, 1'b1, 1'b1, 1'b0);
        checkOutput("idle_kill_nodec", 32'(hwlp_dec_cnt), 32'd0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_kill_noreq", 32'(hwlp_jump_req), 32'd0);

        // Inactive loop at a matching PC
        hwlp_counter[0] = 32'd0;
        applyStimulus(32'h40C, 1'b1, 1'b0, 1'b0);
        checkOutput("inactive_nodec", 32'(hwlp_dec_cnt), 32'd0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("inactive_noreq", 32'(hwlp_jump_req), 32'd0);

        // Reset while in JUMP_REQ, using loop 1 so the index is nonzero beforehand
        hwlp_start_addr = '{32'h500, 32'h0};
        hwlp_end_addr   = '{32'h50C, 32'hFFFC};
        hwlp_counter    = '{32'd3, 32'd0};
        applyStimulus(32'h50C, 1'b1, 1'b0, 1'b0);
        checkOutput("prerst_dec", 32'(hwlp_dec_cnt), 32'd2);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("prerst_req", 32'(hwlp_jump_req), 32'd1);
        checkOutput("prerst_idx", 32'(hwlp_active_idx), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkAllZero("jumprst");

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/cve2_hwloop_controller.md
# cve2_hwloop_controller

Hardware-loop controller: the consumer of the hardware-loop register file. Each cycle it compares the PC of the instruction completing in ID against the stored loop end addresses and counters, emits a one-hot decrement request back to the register file, and issues a held jump request (start address) to the prefetcher until fetch accepts it. It sits between the ID stage, `cve2_hwloop_regs`, and the IF-stage prefetch redirect logic.

## Interface
- `N_REGS`, 2, number of hardware loops (loop 0 is innermost, highest priority)
- `N_REG_BITS`, `$clog2(N_REGS)`, loop index width

- `clk`  in  1  core clock, single clock domain
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`
- `hwlp_start_addr_i`  in  `[N_REGS-1:0][31:0]`  loop start addresses from the register file
- `hwlp_end_addr_i`  in  `[N_REGS-1:0][31:0]`  loop end addresses, the address of the last loop-body instruction
- `hwlp_counter_i`  in  `[N_REGS-1:0][31:0]`  remaining iterations; 0 means the loop is inactive
- `pc_id_i`  in  32  PC of the instruction in ID
- `id_valid_i`  in  1  ID instruction completes this cycle; same qualifier as the register file's `valid_i`
- `kill_i`  in  1  pipeline flush (branch, exception, debug)
- `hwlp_dec_cnt_o`  out  `N_REGS`  one-hot decrement request to the register file
- `hwlp_jump_req_o`  out  1  redirect request to the prefetcher
- `hwlp_jump_addr_o`  out  32  redirect target
- `hwlp_jump_ack_i`  in  1  prefetcher accepts the redirect
- `hwlp_stall_o`  out  1  hold ID; no new instruction may complete
- `hwlp_active_idx_o`  out  `N_REG_BITS`  index of the last serviced loop, for debug and trace

## Operation
- Match vector: `match[k] = (pc_id_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 0)`. This is a full 32-bit compare. Bits [1:0] of the end address are always zero.
- Selection: `sel` is the lowest-index set bit of `match`. There is no service when `match` is all zero.
- Loops that share an end address: only `sel` is serviced. Software must not share end addresses. At most one `hwlp_dec_cnt_o` bit may be high in any cycle.
- FSM, with state type `hwlp_ctrl_state_e`:
  - IDLE:
    - If `id_valid_i && |match && !kill_i`:
      - assert `hwlp_dec_cnt_o[sel]` (combinational, same cycle);
      - latch `hwlp_active_idx_o <= sel`.
    - If, in addition, `hwlp_counter_i[sel] > 1` (unsigned, pre-decrement value):
      - register `hwlp_jump_addr_o <= hwlp_start_addr_i[sel]`;
      - go to JUMP_REQ.
    - If `hwlp_counter_i[sel] == 1`: this is the last iteration. Decrement to 0, stay in IDLE, execution falls through.
  - JUMP_REQ:
    - `hwlp_jump_req_o = 1` and `hwlp_stall_o = 1`.
    - `hwlp_dec_cnt_o` is forced to 0.
    - `hwlp_jump_addr_o` is held stable.
    - On `hwlp_jump_ack_i`: go to IDLE.
    - On `kill_i`: go to IDLE and drop the request. `kill_i` has priority over `hwlp_jump_ack_i`.
- `kill_i` in IDLE suppresses both the decrement and the jump for that cycle.
- Reset values:
  - state = IDLE;
  - `hwlp_jump_req_o = 0`, `hwlp_jump_addr_o = 0`, `hwlp_stall_o = 0`;
  - `hwlp_dec_cnt_o = 0`;
  - `hwlp_active_idx_o = 0`.
- Reset while in JUMP_REQ abandons the request at that clock edge. No decrement is issued.

## Timing
- Decrement: combinational in cycle T, the cycle in which the end-address instruction completes. The register file updates its counter at the end of T.
- Jump request: `hwlp_jump_req_o` is registered and is first high in T+1. It remains high until the cycle of ack or kill, inclusive. It deasserts on the edge after that cycle.
- Minimum request duration is 1 cycle, when ack arrives in T+1. There is no ack timeout.
- `hwlp_jump_addr_o` changes only on the IDLE→JUMP_REQ transition edge. `hwlp_stall_o` equals `hwlp_jump_req_o`.
- A register-file write in cycle T does not influence the match until T+1, because it reads the registered values.
- Back-to-back loop ends are allowed:
  - A single-instruction loop body (start == end) completes at most once every 2 cycles: IDLE, then JUMP_REQ, then IDLE again.
  - Throughput is therefore one iteration per (1 + ack latency) cycles.

## Structure
- Add `hwlp_ctrl_state_e` (`HWLP_IDLE`, `HWLP_JUMP_REQ`) to `cve2_pkg`.
- Add the constant `HWLP_N_REGS = 2` to `cve2_pkg`. This is shared with `cve2_hwloop_regs`.
- No sub-module. The lowest-index priority select is an inline loop. Expected size is about 150 lines.

## Test plan
- **Single loop, 3 iterations.** Loop 0: start 0x100, end 0x10C, counter 3. Complete 0x10C three times, with ack 1 cycle after each request.
  - Iterations 1 and 2: `dec_cnt = 2'b01` on each, then `jump_req` in T+1 with addr 0x100.
  - Iteration 3: counter is 1, so `dec_cnt = 2'b01` and no `jump_req`.
- **Nested loops.** Loop 0: end 0x120, counter 2. Loop 1: end 0x130, counter 2. Complete 0x120 → `dec_cnt = 01` plus a jump. Complete 0x130 → `dec_cnt = 10` plus a jump to loop 1's start.
- **Shared end address.** Both loops have end 0x140 and counter 5. Complete 0x140 → `dec_cnt = 01` only, with jump addr = start[0].
- **Ack delay and kill.** Hold ack low for 4 cycles:
  - `jump_req`, `stall` and addr stay stable for 4 cycles;
  - `kill_i` then drops `jump_req` on the next edge;
  - no extra `dec_cnt` pulses appear.
- **Inactive and reset.** Counter 0 at a matching PC → no dec, no jump. Assert `rst_n = 0` during JUMP_REQ → at the next edge all outputs are 0 and the state is IDLE.
